// File: rtl/car_warning_pkg.sv
// Shared types and default timing constants for the car-warning chime.
package car_warning_pkg;

  // Chime controller states; 3 bits leaves room for future additions.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_QUALIFY  = 3'd1,
    ST_BEEP_ON  = 3'd2,
    ST_BEEP_OFF = 3'd3,
    ST_HOLD     = 3'd4
  } chime_state_t;

  // Default timing, in clock cycles.
  localparam int CHIME_DEBOUNCE = 4;
  localparam int CHIME_ON_CYC   = 8;
  localparam int CHIME_OFF_CYC  = 8;
  localparam int CHIME_BEEP_NUM = 3;

endpackage

// File: rtl/chime_timer.sv
// Shared up-counter for the chime FSM: synchronous clear, terminal compare
// against a limit chosen by the caller each cycle.
module chime_timer #(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             nRst,
  input  logic             Clr,
  input  logic [CNT_W-1:0] Limit,
  output logic             Done
);

  logic [CNT_W-1:0] cnt;

  // Count up every cycle unless cleared; the FSM clears on every state change.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      cnt <= '0;
    end else if (Clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign Done = (cnt == Limit);

endmodule

// File: rtl/car_alarm_chime.sv
// Turns the level Alarm into a debounced, timed buzzer pattern plus a steady
// warning lamp. Alarm and Mute are sampled directly (same clock domain).
// Outputs are registered and decoded from the next state, so they change on
// the same edge the state does. DbgState exposes the current state register.
module car_alarm_chime
  import car_warning_pkg::*;
#(
  parameter int DEBOUNCE = CHIME_DEBOUNCE,
  parameter int ON_CYC   = CHIME_ON_CYC,
  parameter int OFF_CYC  = CHIME_OFF_CYC,
  parameter int BEEP_NUM = CHIME_BEEP_NUM,
  parameter int CNT_W    = 8,
  localparam int BW      = $clog2(BEEP_NUM + 1)
) (
  input  logic          Clk,
  input  logic          nRst,
  input  logic          Alarm,
  input  logic          Mute,
  output logic          Buzzer,
  output logic          Lamp,
  output logic          Busy,
  output logic [BW-1:0] BeepCnt,
  output chime_state_t  DbgState
);

  localparam logic [CNT_W-1:0] LIM_DEB = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] LIM_ON  = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] LIM_OFF = CNT_W'(OFF_CYC - 1);
  localparam logic [BW-1:0]    BEEP_MAX = BW'(BEEP_NUM);

  chime_state_t     state;
  chime_state_t     nxt_state;
  logic [BW-1:0]    nxt_beep;
  logic             tmr_clr;
  logic [CNT_W-1:0] tmr_limit;
  logic             tmr_done;

  chime_timer #(.CNT_W(CNT_W)) u_timer (
    .Clk   (Clk),
    .nRst  (nRst),
    .Clr   (tmr_clr),
    .Limit (tmr_limit),
    .Done  (tmr_done)
  );

  // Next-state, beep count and timer control. Priority: Alarm low, then
  // Mute, then timer expiry. The timer is cleared unless it must keep counting.
  always_comb begin
    nxt_state = state;
    nxt_beep  = BeepCnt;
    tmr_clr   = 1'b1;
    tmr_limit = '0;
    case (state)
      ST_IDLE: begin
        if (Alarm) nxt_state = ST_QUALIFY;
      end
      ST_QUALIFY: begin
        tmr_limit = LIM_DEB;
        if (!Alarm)        nxt_state = ST_IDLE;
        else if (tmr_done) nxt_state = ST_BEEP_ON;
        else               tmr_clr   = 1'b0;
      end
      ST_BEEP_ON: begin
        tmr_limit = LIM_ON;
        if (!Alarm) begin
          nxt_state = ST_IDLE;
          nxt_beep  = '0;
        end else if (Mute) begin
          nxt_state = ST_HOLD;
        end else if (tmr_done) begin
          nxt_state = ST_BEEP_OFF;
          if (BeepCnt != BEEP_MAX) nxt_beep = BeepCnt + 1'b1;
        end else begin
          tmr_clr = 1'b0;
        end
      end
      ST_BEEP_OFF: begin
        tmr_limit = LIM_OFF;
        if (!Alarm) begin
          nxt_state = ST_IDLE;
          nxt_beep  = '0;
        end else if (Mute) begin
          nxt_state = ST_HOLD;
        end else if (tmr_done) begin
          nxt_state = (BeepCnt == BEEP_MAX) ? ST_HOLD : ST_BEEP_ON;
        end else begin
          tmr_clr = 1'b0;
        end
      end
      ST_HOLD: begin
        if (!Alarm) begin
          nxt_state = ST_IDLE;
          nxt_beep  = '0;
        end
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_beep  = '0;
      end
    endcase
  end

  // State, beep count and Moore outputs decoded from the next state.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state   <= ST_IDLE;
      BeepCnt <= '0;
      Buzzer  <= 1'b0;
      Lamp    <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      state   <= nxt_state;
      BeepCnt <= nxt_beep;
      Buzzer  <= (nxt_state == ST_BEEP_ON);
      Lamp    <= (nxt_state == ST_BEEP_ON) || (nxt_state == ST_BEEP_OFF) ||
                 (nxt_state == ST_HOLD);
      Busy    <= (nxt_state != ST_IDLE);
    end
  end

  assign DbgState = state;

endmodule
